cut_bist_ctrl: RTL



---
 rtl/cut_bist_pkg.sv | 26 ++
 rtl/cut_bist_ctrl_if.sv | 29 ++
 rtl/bist_misr.sv | 27 ++
 rtl/cut_bist_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/cut_bist_pkg.sv
// Shared types, LFSR/MISR constants and next-state helpers for the CUT BIST
// sequencer and its MISR compactor.
package cut_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CAPTURE,
        DONE
    } bist_state_t;

    // Tap mask for taps 26, 4, 1 and 0 of the 27-bit pattern generator
    localparam logic [26:0] LFSR27_TAPS = 27'h400_0013;

    // x^29 + x^27 + 1, folded in after the shift
    localparam logic [28:0] POLY_MISR29 = 29'h0800_0001;

    function automatic logic [26:0] lfsr_next(input logic [26:0] cur);
        return {cur[25:0], ^(cur & LFSR27_TAPS)};
    endfunction

    function automatic logic [28:0] misr_next(input logic [28:0] cur, input logic [28:0] data);
        return {cur[27:0], 1'b0} ^ (cur[28] ? POLY_MISR29 : 29'h0) ^ data;
    endfunction

endpackage

// File: rtl/cut_bist_ctrl_if.sv
// Control, status and CUT-facing signals of one BIST sequencer instance.
interface cut_bist_ctrl_if #(
    parameter int N_IN  = 27,
    parameter int N_OUT = 29,
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [N_IN-1:0]  seed;
    logic [CNT_W-1:0] n_patterns;
    logic [N_OUT-1:0] golden;
    logic [N_IN-1:0]  cut_x;
    logic [N_OUT-1:0] cut_f;
    logic             busy;
    logic             done;
    logic             pass;
    logic [N_OUT-1:0] signature;
    logic [CNT_W-1:0] pattern_cnt;

    modport master (
        output start, abort, seed, n_patterns, golden, cut_f,
        input  cut_x, busy, done, pass, signature, pattern_cnt
    );

    modport slave (
        input  start, abort, seed, n_patterns, golden, cut_f,
        output cut_x, busy, done, pass, signature, pattern_cnt
    );
endinterface

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift, fold the feedback polynomial in,
// then XOR the parallel data word. Clear has priority over enable.
module bist_misr
    import cut_bist_pkg::*;
#(
    parameter int               WIDTH = 29,
    parameter logic [WIDTH-1:0] POLY  = POLY_MISR29
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (enable) begin
            sig <= {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ data;
        end
    end

endmodule

// File: rtl/cut_bist_ctrl.sv
// BIST sequencer: drives CUT inputs from a 27-bit LFSR, waits a settle time per
// pattern, compacts CUT outputs into a MISR and compares against a golden value.
module cut_bist_ctrl
    import cut_bist_pkg::*;
#(
    parameter int N_IN       = 27,
    parameter int N_OUT      = 29,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 1
) (
    input logic            clk,
    input logic            rst_n,
    cut_bist_ctrl_if.slave bus
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC - 1);

    bist_state_t      state;
    bist_state_t      state_next;
    logic [3:0]       settle_cnt;
    logic [N_IN-1:0]  lfsr;
    logic [N_IN-1:0]  seed_eff;
    logic [CNT_W-1:0] n_pat;
    logic [CNT_W-1:0] cnt_inc;
    logic [N_OUT-1:0] golden_q;
    logic [N_OUT-1:0] misr;
    logic             run_load;
    logic             run_capture;

    // An all-zero seed would lock the LFSR, so it is replaced by 1
    assign seed_eff = (bus.seed == '0) ? N_IN'(1) : bus.seed;
    assign cnt_inc  = bus.pattern_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_next = (bus.n_patterns == '0) ? DONE : APPLY;
                end
            end
            APPLY: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (settle_cnt == '0) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (cnt_inc == n_pat) begin
                    state_next = DONE;
                end else begin
                    state_next = APPLY;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state == APPLY) || (state == CAPTURE);
        bus.done    = (state == DONE);
        run_load    = (state == IDLE) && bus.start && !bus.abort;
        run_capture = (state == CAPTURE) && !bus.abort;
    end

    // pass drops at start so an aborted run can never leave a stale pass behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr            <= '0;
            bus.cut_x       <= '0;
            bus.pattern_cnt <= '0;
            bus.signature   <= '0;
            bus.pass        <= 1'b0;
            n_pat           <= '0;
            golden_q        <= '0;
            settle_cnt      <= '0;
        end else begin
            if (run_load) begin
                bus.pattern_cnt <= '0;
                bus.pass        <= 1'b0;
                n_pat           <= bus.n_patterns;
                golden_q        <= bus.golden;
                settle_cnt      <= SETTLE_INIT;
                if (bus.n_patterns != '0) begin
                    lfsr      <= seed_eff;
                    bus.cut_x <= seed_eff;
                end
            end
            if ((state == APPLY) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
            if (run_capture) begin
                lfsr            <= lfsr_next(lfsr);
                bus.pattern_cnt <= cnt_inc;
                settle_cnt      <= SETTLE_INIT;
                if (cnt_inc != n_pat) begin
                    bus.cut_x <= lfsr_next(lfsr);
                end
            end
            if (state == DONE) begin
                bus.signature <= misr;
                bus.pass      <= (misr == golden_q);
            end
        end
    end

    bist_misr #(
        .WIDTH (N_OUT)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (run_load),
        .enable (run_capture),
        .data   (bus.cut_f),
        .sig    (misr)
    );

endmodule
